// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg                                                              |
// | Shared types for the execute unit: ALU control codes, RV32M op       |
// | encoding, FSM states and instruction-field constants.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0010,
    ALU_SLL  = 4'b0100,
    ALU_SLT  = 4'b0110,
    ALU_SRL  = 4'b1000,
    ALU_XOR  = 4'b1010,
    ALU_SLTU = 4'b1011,
    ALU_OR   = 4'b1100,
    ALU_AND  = 4'b1110,
    ALU_SRA  = 4'b1111
  } alu_ctrl_e;

  // Values equal funct3 of the M-extension instructions
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } fsm_state_e;

  localparam logic [6:0] c_opc_rtype = 7'b0110011;
  localparam logic [6:0] c_f7_muldiv = 7'b0000001;

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_op_decode                                                        |
// | Combinational decode of alu_op/funct3/funct7/opcode into an ALU      |
// | control code, plus RV32M detection and illegal-encoding flag.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  input  logic [6:0] i_opcode,
  output alu_ctrl_e  o_ctrl,
  output logic       o_is_muldiv,
  output muldiv_op_e o_muldiv_op,
  output logic       o_illegal
);

  // Only opcode[5] (register vs immediate form) matters to this decode
  logic w_unused_opc;
  assign w_unused_opc = ^{i_opcode[6], i_opcode[4:0]};

  always_comb begin
    o_ctrl      = ALU_ADD;
    o_illegal   = 1'b0;
    o_is_muldiv = (i_alu_op == 2'b10) && i_opcode[5] && (i_funct7 == c_f7_muldiv);
    o_muldiv_op = muldiv_op_e'(i_funct3);
    case (i_alu_op)
      2'b00: o_ctrl = ALU_ADD;
      2'b01: begin
        case (i_funct3)
          3'b000, 3'b001: o_ctrl = ALU_SUB;
          3'b100, 3'b101: o_ctrl = ALU_SLT;
          3'b110, 3'b111: o_ctrl = ALU_SLTU;
          default:        o_illegal = 1'b1;
        endcase
      end
      2'b10: begin
        case (i_funct3)
          3'b000:  o_ctrl = (i_opcode[5] && i_funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b001:  o_ctrl = ALU_SLL;
          3'b010:  o_ctrl = ALU_SLT;
          3'b011:  o_ctrl = ALU_SLTU;
          3'b100:  o_ctrl = ALU_XOR;
          3'b101:  o_ctrl = i_funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  o_ctrl = ALU_OR;
          default: o_ctrl = ALU_AND;
        endcase
      end
      default: o_ctrl = ALU_SLL;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_muldiv_unit                                                      |
// | Sequential execute unit: single-cycle base ALU plus iterative RV32M  |
// | multiply/divide behind a valid/ready handshake.                      |
// | Build option: define ALU_MULDIV_DIV_EN to include the divider.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_muldiv_unit
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [6:0]      opcode,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int c_shw   = $clog2(XLEN);
  localparam int c_cnt_w = $clog2(XLEN + 1);
  localparam logic [c_cnt_w-1:0] c_mul_steps = c_cnt_w'(XLEN / MUL_UNROLL);
  localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(1);

  fsm_state_e         r_state, w_state_nxt;
  alu_ctrl_e          w_ctrl;
  muldiv_op_e         w_md_op, r_op;
  logic               w_is_md, w_dec_ill;
  logic [c_cnt_w-1:0] r_cnt;
  logic [2*XLEN-1:0]  r_acc, r_mcand, w_mul_acc, w_prod;
  logic [XLEN-1:0]    r_mplier, r_result, w_alu_res, w_imm_res, w_mul_res, w_a_mag, w_b_mag;
  logic [c_shw-1:0]   w_shamt;
  logic               r_neg_q, r_zero, r_illegal;
  logic               w_accept, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic               w_go_mul, w_go_div, w_imm_ill;

  alu_op_decode u_dec (
    .i_alu_op    (alu_op),
    .i_funct3    (funct3),
    .i_funct7    (funct7),
    .i_opcode    (opcode),
    .o_ctrl      (w_ctrl),
    .o_is_muldiv (w_is_md),
    .o_muldiv_op (w_md_op),
    .o_illegal   (w_dec_ill)
  );

  assign in_ready = (r_state == S_IDLE) || (r_state == S_DONE);
  assign done     = (r_state == S_DONE);
  assign result   = r_result;
  assign zero     = r_zero;
  assign illegal  = r_illegal & done;
  assign w_accept = in_valid & in_ready & ~flush;
  assign w_shamt  = src_b[c_shw-1:0];

  always_comb begin
    w_alu_res = '0;
    case (w_ctrl)
      ALU_ADD:  w_alu_res = src_a + src_b;
      ALU_SUB:  w_alu_res = src_a - src_b;
      ALU_SLL:  w_alu_res = src_a << w_shamt;
      ALU_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      ALU_SRL:  w_alu_res = src_a >> w_shamt;
      ALU_SRA:  w_alu_res = $unsigned($signed(src_a) >>> w_shamt);
      ALU_XOR:  w_alu_res = src_a ^ src_b;
      ALU_OR:   w_alu_res = src_a | src_b;
      ALU_AND:  w_alu_res = src_a & src_b;
      default:  w_alu_res = '0;
    endcase
  end

  // Iterations run on magnitudes; the sign is reapplied on the final step
  assign w_a_signed = (w_md_op == MD_MULH) || (w_md_op == MD_MULHSU) ||
                      (w_md_op == MD_DIV)  || (w_md_op == MD_REM);
  assign w_b_signed = (w_md_op == MD_MULH) || (w_md_op == MD_DIV) || (w_md_op == MD_REM);
  assign w_a_neg    = w_a_signed & src_a[XLEN-1];
  assign w_b_neg    = w_b_signed & src_b[XLEN-1];
  assign w_a_mag    = w_a_neg ? -src_a : src_a;
  assign w_b_mag    = w_b_neg ? -src_b : src_b;

  always_comb begin
    w_mul_acc = r_acc;
    for (int k = 0; k < MUL_UNROLL; k++) begin
      if (r_mplier[k]) w_mul_acc = w_mul_acc + (r_mcand << k);
    end
  end
  assign w_prod    = r_neg_q ? -w_mul_acc : w_mul_acc;
  assign w_mul_res = (r_op == MD_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

`ifdef ALU_MULDIV_DIV_EN
  localparam logic [c_cnt_w-1:0] c_div_steps = c_cnt_w'(XLEN);
  localparam logic [XLEN-1:0]    c_int_min   = {1'b1, {(XLEN-1){1'b0}}};

  logic [XLEN:0]   w_rem_sh, w_diff;
  logic [XLEN-1:0] w_div_rem, w_div_quo, w_div_res, w_spec_res;
  logic            w_div_by0, w_div_ovf, w_acc_is_rem, w_op_is_rem, r_neg_r;

  // Remainder lives in r_acc, dividend/quotient shift through r_mplier
  assign w_rem_sh     = {r_acc[XLEN-1:0], r_mplier[XLEN-1]};
  assign w_diff       = w_rem_sh - {1'b0, r_mcand[XLEN-1:0]};
  assign w_div_rem    = w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
  assign w_div_quo    = {r_mplier[XLEN-2:0], ~w_diff[XLEN]};
  assign w_acc_is_rem = (r_op == MD_REM) || (r_op == MD_REMU);
  assign w_div_res    = w_acc_is_rem ? (r_neg_r ? -w_div_rem : w_div_rem)
                                     : (r_neg_q ? -w_div_quo : w_div_quo);

  assign w_op_is_rem  = (w_md_op == MD_REM) || (w_md_op == MD_REMU);
  assign w_div_by0    = (src_b == '0);
  assign w_div_ovf    = ((w_md_op == MD_DIV) || (w_md_op == MD_REM)) &&
                        (src_a == c_int_min) && (src_b == '1);
  assign w_spec_res   = w_div_by0 ? (w_op_is_rem ? src_a : '1)
                                  : (w_op_is_rem ? '0 : c_int_min);
`endif

  always_comb begin
    w_imm_res = w_dec_ill ? '0 : w_alu_res;
    w_imm_ill = w_dec_ill;
    w_go_mul  = 1'b0;
    w_go_div  = 1'b0;
    if (w_is_md) begin
      w_imm_ill = 1'b0;
      if (!w_md_op[2]) begin
        w_go_mul = 1'b1;
      end else begin
`ifdef ALU_MULDIV_DIV_EN
        if (w_div_by0 || w_div_ovf) w_imm_res = w_spec_res;
        else                        w_go_div  = 1'b1;
`else
        w_imm_res = '0;
        w_imm_ill = 1'b1;
`endif
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          if (w_go_mul)      w_state_nxt = S_MUL;
          else if (w_go_div) w_state_nxt = S_DIV;
          else               w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MUL: begin
        if (flush)                    w_state_nxt = S_IDLE;
        else if (r_cnt == c_cnt_last) w_state_nxt = S_DONE;
      end
`ifdef ALU_MULDIV_DIV_EN
      S_DIV: begin
        if (flush)                    w_state_nxt = S_IDLE;
        else if (r_cnt == c_cnt_last) w_state_nxt = S_DONE;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= MD_MUL;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_neg_q   <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b1;
      r_illegal <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
      r_neg_r   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_op      <= w_md_op;
      r_illegal <= w_imm_ill;
      r_acc     <= '0;
      r_neg_q   <= w_a_neg ^ w_b_neg;
      if (w_go_mul) begin
        r_mcand  <= {{XLEN{1'b0}}, w_a_mag};
        r_mplier <= w_b_mag;
        r_cnt    <= c_mul_steps;
`ifdef ALU_MULDIV_DIV_EN
      end else if (w_go_div) begin
        r_mcand  <= {{XLEN{1'b0}}, w_b_mag};
        r_mplier <= w_a_mag;
        r_neg_r  <= w_a_neg;
        r_cnt    <= c_div_steps;
`endif
      end else begin
        r_result <= w_imm_res;
        r_zero   <= (w_imm_res == '0);
      end
    end else if (r_state == S_MUL) begin
      if (flush) begin
        r_cnt <= '0;
      end else begin
        r_acc    <= w_mul_acc;
        r_mcand  <= r_mcand << MUL_UNROLL;
        r_mplier <= r_mplier >> MUL_UNROLL;
        r_cnt    <= r_cnt - 1'b1;
        if (r_cnt == c_cnt_last) begin
          r_result <= w_mul_res;
          r_zero   <= (w_mul_res == '0);
        end
      end
`ifdef ALU_MULDIV_DIV_EN
    end else if (r_state == S_DIV) begin
      if (flush) begin
        r_cnt <= '0;
      end else begin
        r_acc    <= {{XLEN{1'b0}}, w_div_rem};
        r_mplier <= w_div_quo;
        r_cnt    <= r_cnt - 1'b1;
        if (r_cnt == c_cnt_last) begin
          r_result <= w_div_res;
          r_zero   <= (w_div_res == '0);
        end
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_muldiv_unit                                                   |
// | Directed self-checking bench for alu_muldiv_unit (XLEN=32).          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_alu_muldiv_unit;

  localparam int XLEN = 32;
  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_B  = 7'b1100011;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_LU = 7'b0110111;
  localparam logic [6:0] F7_M   = 7'b0000001;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            flush = 1'b0;
  logic [1:0]      alu_op = '0;
  logic [2:0]      funct3 = '0;
  logic [6:0]      funct7 = '0;
  logic [6:0]      opcode = '0;
  logic [XLEN-1:0] src_a = '0;
  logic [XLEN-1:0] src_b = '0;
  logic            in_ready, done, zero, illegal;
  logic [XLEN-1:0] result;
  logic            in_ready_4, done_4, zero_4, illegal_4;
  logic [XLEN-1:0] result_4;

  int          n_checks = 0;
  int          n_errors = 0;
  int          g_lat, g_lat4, g_nrdy;
  logic [31:0] g_r4;

  alu_muldiv_unit #(.XLEN(XLEN), .MUL_UNROLL(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .opcode(opcode),
    .src_a(src_a), .src_b(src_b), .done(done), .result(result), .zero(zero), .illegal(illegal)
  );

  alu_muldiv_unit #(.XLEN(XLEN), .MUL_UNROLL(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_4), .flush(flush),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .opcode(opcode),
    .src_a(src_a), .src_b(src_b), .done(done_4), .result(result_4), .zero(zero_4),
    .illegal(illegal_4)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op from IDLE; return in the cycle done rises (or at the bound)
  task automatic run_op(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [6:0] opc, input logic [31:0] a, input logic [31:0] b);
    alu_op = op; funct3 = f3; funct7 = f7; opcode = opc; src_a = a; src_b = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    g_lat = 1; g_lat4 = 0; g_nrdy = 0; g_r4 = '0;
    while (1) begin
      if (done_4 && g_lat4 == 0) begin
        g_lat4 = g_lat;
        g_r4   = result_4;
      end
      if (done || g_lat >= 100) break;
      if (!in_ready) g_nrdy++;
      @(posedge clk); #1;
      g_lat++;
    end
  endtask

  task automatic run_chk(input string tag, input logic [1:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [6:0] opc, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                         input logic exp_ill);
    run_op(op, f3, f7, opc, a, b);
    check({tag, "_lat"}, 64'(g_lat), 64'(exp_lat));
    check({tag, "_res"}, 64'(result), 64'(exp_res));
    check({tag, "_zero"}, 64'(zero), 64'(exp_res == 32'h0));
    check({tag, "_ill"}, 64'(illegal), 64'(exp_ill));
    @(posedge clk); #1;
  endtask

  initial begin
    int nd;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(in_ready), 64'(1));
    check("rst_done", 64'(done), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_zero", 64'(zero), 64'(1));
    check("rst_illegal", 64'(illegal), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD then branch SUB on consecutive accepts
    alu_op = 2'b10; funct3 = 3'b000; funct7 = 7'h00; opcode = OPC_R;
    src_a = 32'd5; src_b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    check("add_done", 64'(done), 64'(1));
    check("add_res", 64'(result), 64'(12));
    check("add_zero", 64'(zero), 64'(0));
    check("add_ready", 64'(in_ready), 64'(1));
    alu_op = 2'b01; funct3 = 3'b000; opcode = OPC_B; src_a = 32'h10; src_b = 32'h10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("beq_done", 64'(done), 64'(1));
    check("beq_res", 64'(result), 64'(0));
    check("beq_zero", 64'(zero), 64'(1));
    @(posedge clk); #1;
    check("done_pulse", 64'(done), 64'(0));

    run_chk("sub_r",   2'b10, 3'b000, 7'h20, OPC_R,  32'd5, 32'd7, 32'hFFFFFFFE, 1, 1'b0);
    run_chk("addi_f7", 2'b10, 3'b000, 7'h20, OPC_I,  32'd5, 32'd7, 32'd12, 1, 1'b0);
    run_chk("slt",     2'b10, 3'b010, 7'h00, OPC_R,  32'hFFFFFFFF, 32'd1, 32'd1, 1, 1'b0);
    run_chk("sltu",    2'b10, 3'b011, 7'h00, OPC_R,  32'hFFFFFFFF, 32'd1, 32'd0, 1, 1'b0);
    run_chk("sra",     2'b10, 3'b101, 7'h20, OPC_R,  32'h80000000, 32'd4, 32'hF8000000, 1, 1'b0);
    run_chk("srl",     2'b10, 3'b101, 7'h00, OPC_R,  32'h80000000, 32'd36, 32'h08000000, 1, 1'b0);
    run_chk("xor",     2'b10, 3'b100, 7'h00, OPC_R,  32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1, 1'b0);
    run_chk("and",     2'b10, 3'b111, 7'h00, OPC_R,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1, 1'b0);
    run_chk("lui_sll", 2'b11, 3'b000, 7'h00, OPC_LU, 32'd1, 32'h25, 32'd32, 1, 1'b0);
    run_chk("ld_add",  2'b00, 3'b010, 7'h00, OPC_LD, 32'd100, 32'hFFFFFFFC, 32'd96, 1, 1'b0);
    run_chk("blt",     2'b01, 3'b100, 7'h00, OPC_B,  32'hFFFFFFFF, 32'd0, 32'd1, 1, 1'b0);
    run_chk("bgeu",    2'b01, 3'b111, 7'h00, OPC_B,  32'hFFFFFFFF, 32'd0, 32'd0, 1, 1'b0);
    run_chk("br_ill",  2'b01, 3'b010, 7'h00, OPC_B,  32'd3, 32'd4, 32'd0, 1, 1'b1);

    run_chk("mul",     2'b10, 3'b000, F7_M, OPC_R, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, 33, 1'b0);
    check("mul_busy_cycles", 64'(g_nrdy), 64'(32));
    check("mul4_lat", 64'(g_lat4), 64'(9));
    check("mul4_res", 64'(g_r4), 64'(32'hFFFFFFFA));
    run_chk("mulh",    2'b10, 3'b001, F7_M, OPC_R, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 33, 1'b0);
    run_chk("mulhsu",  2'b10, 3'b010, F7_M, OPC_R, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 33, 1'b0);
    run_chk("mulhu",   2'b10, 3'b011, F7_M, OPC_R, 32'hFFFFFFFE, 32'd3, 32'h00000002, 33, 1'b0);
    run_chk("mul_lo",  2'b10, 3'b000, F7_M, OPC_R, 32'h12345678, 32'h100, 32'h34567800, 33, 1'b0);
    run_chk("mul_0",   2'b10, 3'b000, F7_M, OPC_R, 32'd0, 32'd5, 32'd0, 33, 1'b0);

`ifdef ALU_MULDIV_DIV_EN
    run_chk("div",     2'b10, 3'b100, F7_M, OPC_R, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 1'b0);
    run_chk("rem",     2'b10, 3'b110, F7_M, OPC_R, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 1'b0);
    run_chk("divu",    2'b10, 3'b101, F7_M, OPC_R, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    run_chk("remu",    2'b10, 3'b111, F7_M, OPC_R, 32'd100, 32'd7, 32'd2, 33, 1'b0);
    run_chk("divu_0",  2'b10, 3'b101, F7_M, OPC_R, 32'd9, 32'd0, 32'hFFFFFFFF, 1, 1'b0);
    run_chk("remu_0",  2'b10, 3'b111, F7_M, OPC_R, 32'd9, 32'd0, 32'd9, 1, 1'b0);
    run_chk("div_ovf", 2'b10, 3'b100, F7_M, OPC_R, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b0);
    run_chk("rem_ovf", 2'b10, 3'b110, F7_M, OPC_R, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 1'b0);
`else
    run_chk("div_off", 2'b10, 3'b100, F7_M, OPC_R, 32'd8, 32'd2, 32'd0, 1, 1'b1);
    run_chk("rem_off", 2'b10, 3'b110, F7_M, OPC_R, 32'd8, 32'd3, 32'd0, 1, 1'b1);
`endif

    // Flush during a multiply: no done, result keeps the previous value
    run_chk("pre_flush", 2'b10, 3'b110, 7'h00, OPC_R, 32'h000000F0, 32'h00000F00, 32'h00000FF0, 1, 1'b0);
    alu_op = 2'b10; funct3 = 3'b000; funct7 = F7_M; opcode = OPC_R;
    src_a = 32'd7; src_b = 32'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_ready", 64'(in_ready), 64'(1));
    check("flush_done", 64'(done), 64'(0));
    check("flush_res", 64'(result), 64'(32'h00000FF0));
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("flush_no_late_done", 64'(nd), 64'(0));

    // Flush coinciding with a request blocks the accept
    alu_op = 2'b10; funct3 = 3'b000; funct7 = 7'h00; src_a = 32'd1; src_b = 32'd1;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_acc_done", 64'(done), 64'(0));
    check("flush_acc_res", 64'(result), 64'(32'h00000FF0));

    // Asynchronous reset in the middle of an iterative op
`ifdef ALU_MULDIV_DIV_EN
    funct3 = 3'b100;
`else
    funct3 = 3'b000;
`endif
    alu_op = 2'b10; funct7 = F7_M; opcode = OPC_R; src_a = 32'd100; src_b = 32'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_op_busy", 64'(in_ready), 64'(0));
    rst_n = 1'b0;
    #1;
    check("arst_ready", 64'(in_ready), 64'(1));
    check("arst_done", 64'(done), 64'(0));
    check("arst_result", 64'(result), 64'(0));
    check("arst_zero", 64'(zero), 64'(1));
    check("arst_illegal", 64'(illegal), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_chk("post_rst", 2'b10, 3'b000, 7'h00, OPC_R, 32'd2, 32'd3, 32'd5, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_muldiv_unit.md
# alu_muldiv_unit

Parametrised sequential execute unit for the multicycle RISC-V core. It decodes `alu_op`/`funct3`/`funct7`/`opcode` into the base ALU control codes and adds the RV32M multiply/divide ops on an iterative datapath. It sits between the control FSM and the register/ALU-out path, and the control FSM stalls on a valid/ready handshake.

## Interface
- `XLEN`, 32: operand/result width; power of two, ≥ 8.
- `MUL_UNROLL`, 1: multiplier bits retired per cycle; one of 1, 2, 4; must divide `XLEN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: unit can accept.
- `flush` in 1: synchronous abort of the in-flight op.
- `alu_op` in 2: 00 load/store, 01 branch, 10 R/I arithmetic, 11 LUI.
- `funct3` in 3, `funct7` in 7, `opcode` in 7: instruction fields.
- `src_a`, `src_b` in `XLEN`: operands.
- `done` out 1: one-cycle pulse; result valid.
- `result` out `XLEN`: held until the next accept.
- `zero` out 1: `result == 0`, registered with `result`.
- `illegal` out 1: decode unsupported; pulses together with `done`.

## Operation
- Base codes: ADD 0000, SUB 0010, SLL 0100, SLT 0110, SRL 1000, XOR 1010, OR 1100, AND 1110, SRA 1111, SLTU 1011.
- Decode by `alu_op`:
  - 00 → ADD.
  - 01 → by `funct3`: BEQ/BNE → SUB, BLT/BGE → SLT, BLTU/BGEU → SLTU; `funct3` 010/011 → `illegal`, result 0.
  - 10 → by `funct3`: 000 is ADD, or SUB only when `opcode[5]` and `funct7[5]` are both set; 101 is SRL, or SRA when `funct7[5]` is set; the rest map directly.
  - 11 → SLL.
- M ops: `alu_op`=10, `opcode[5]`=1, `funct7`=0000001. `funct3` 000..111 = MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Shift amounts use `src_b[$clog2(XLEN)-1:0]`.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: `in_ready`=1. On `in_valid`, base ops compute and register directly into DONE; M ops load operands, and the step counter goes to MUL or DIV.
  - MUL: shift-add on magnitudes, `MUL_UNROLL` bits per cycle, 2·`XLEN` product. Counter reaches 0 → DONE.
  - DIV: restoring division, 1 quotient bit per cycle. Counter reaches 0 → DONE.
  - DONE: sign-correct, then select the low half, high half, quotient or remainder. Assert `done` and `in_ready`. A new accept in DONE is legal; otherwise go to IDLE.
- Signs:
  - MULH treats both operands as signed.
  - MULHSU treats `src_a` as signed and `src_b` as unsigned.
  - Quotient is negative iff the operand signs differ; remainder takes the dividend's sign.
- Special cases, which skip iteration and go straight to DONE:
  - Divide by 0: quotient all-ones; remainder = dividend.
  - Signed overflow (MIN ÷ −1): quotient MIN, remainder 0.
- Boundaries:
  - `in_valid` while `in_ready`=0 is ignored; the source must hold it.
  - `flush` in MUL or DIV → IDLE next cycle, no `done`; `result` is unchanged.
  - `flush` together with an accept: `flush` wins.
  - `rst_n` low mid-op: immediate return to reset values.
- Reset values: state IDLE, `in_ready` 1, `done` 0, `result` 0, `zero` 1, `illegal` 0, counter 0.

## Timing
- Latency L is measured from the accept edge to the cycle in which `done` is high:
  - Base ops and special cases: L = 1.
  - MUL family: L = `XLEN`/`MUL_UNROLL` + 1.
  - DIV family: L = `XLEN` + 1.
- `done` is high for exactly one cycle. `result`, `zero` and `illegal` are valid in that cycle and stable afterwards.
- Back-to-back base ops achieve throughput 1 per cycle.

## Configuration
- `ALU_MULDIV_DIV_EN`:
  - Defined: DIV/DIVU/REM/REMU run on the iterative divider as above.
  - Undefined: the divider and DIV state are not built. Those ops complete at L = 1 with `result` 0 and `illegal`=1. MUL ops are unaffected.

## Structure
- Package `alu_pkg` holds:
  - The `alu_ctrl_e` enum with the 4-bit codes.
  - The `muldiv_op_e` enum.
  - The FSM state enum.
  - The R-type opcode constant 0110011 and the M `funct7` constant 0000001.
- Sub-module `alu_op_decode`: combinational decode to `alu_ctrl_e`, plus the `is_muldiv`, `muldiv_op` and `illegal` outputs.

## Test plan
- ADD: `alu_op`=10, `funct3`=000, `funct7`=0, `opcode`=0110011, operands 5 and 7 → `done` at L=1, `result` 12, `zero` 0.
- Branch SUB: `alu_op`=01, `funct3`=000, `src_a`=`src_b`=0x10 → `result` 0, `zero` 1, back-to-back with the previous op.
- MUL/MULH with 0xFFFFFFFE × 3:
  - MUL → 0xFFFFFFFA at L=33.
  - MULH → 0xFFFFFFFF.
  - `in_ready` is low for cycles 1..32.
  - With `MUL_UNROLL`=4, MUL completes at L=9.
- DIV/REM:
  - DIV −7 ÷ 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; both at L=33.
  - DIVU 9 ÷ 0 → 0xFFFFFFFF and REMU → 9, both at L=1.
  - DIV 0x80000000 ÷ −1 → 0x80000000 at L=1.
- Abort and reset:
  - `flush` at cycle 10 of MUL → no `done`, `in_ready`=1 next cycle.
  - `rst_n` low mid-DIV → all outputs at reset values immediately.
- Macro off: DIV 8 ÷ 2 → `result` 0 and `illegal`=1 at L=1.
